// File: rtl/sregs_mmu.sv
// sregs_mmu - paging/protection unit for the core's special-register space.
//
// Translates data and program virtual addresses through two page tables,
// each entry holding valid, write-protect and a physical page number. The
// first translation fault is latched (status + faulting address) for the
// IRQ handler; later faults only set the overflow flag until it is cleared.
//
// Register map (sr_sel):
//   CTRL_SEL+0  CTRL   [0]=den [1]=pen [2]=pen_buf [4:3]=saved {pen,den}
//   CTRL_SEL+1  FSTAT  [0]=valid [1]=chan [2]=cause [3]=overflow
//   CTRL_SEL+2  FADDR  virtual address of the latched fault
//   CTRL_SEL+3  FCLR   write clears FSTAT/FADDR, reads 0
//   DPT_SEL+n   data page table entry n     [15]=valid [14]=wp [PPN_W-1:0]=ppn
//   PPT_SEL+n   program page table entry n  (same layout)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_sr_ie/sel/in  special-register write strobe, select, write data
//   o_sr_out        read data, 0 outside this block's windows
//   i_sup           supervisor mode; non-supervisor writes are dropped
//   i_irq_entry     interrupt entry pulse: paging off, old {pen,den} saved
//   i_jmp_commit    jump commit: pen takes pen_buf
//   i_d_*/o_d_*     data channel request, translation and fault
//   i_p_*/o_p_*     program channel request, translation, page and fault
//   o_fault_pend    FSTAT.valid
module sregs_mmu #(
  parameter int          VADDR_W    = 16,
  parameter int          PAGE_IDX_W = 4,
  parameter int          PPN_W      = 8,
  parameter logic [15:0] CTRL_SEL   = 16'h0040,
  parameter logic [15:0] DPT_SEL    = 16'h0050,
  parameter logic [15:0] PPT_SEL    = 16'h0060,
  localparam int         PADDR_W    = PPN_W + VADDR_W - PAGE_IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_sr_ie,
  input  logic [15:0]        i_sr_sel,
  input  logic [15:0]        i_sr_in,
  output logic [15:0]        o_sr_out,
  input  logic               i_sup,
  input  logic               i_irq_entry,
  input  logic               i_jmp_commit,
  input  logic               i_d_req,
  input  logic               i_d_we,
  input  logic [VADDR_W-1:0] i_d_vaddr,
  output logic [PADDR_W-1:0] o_d_paddr,
  input  logic               i_p_req,
  input  logic [VADDR_W-1:0] i_p_vaddr,
  output logic [PADDR_W-1:0] o_p_paddr,
  output logic [PPN_W-1:0]   o_p_page,
  output logic               o_d_fault,
  output logic               o_p_fault,
  output logic               o_fault_pend
);

  localparam int DEPTH = 1 << PAGE_IDX_W;
  localparam int OFF_W = VADDR_W - PAGE_IDX_W;

  function automatic bit f_overlap(int a, int la, int b, int lb);
    return (a < b + lb) && (b < a + la);
  endfunction

  localparam bit SEL_OVERLAP =
    f_overlap(int'(CTRL_SEL), 4, int'(DPT_SEL), DEPTH) ||
    f_overlap(int'(CTRL_SEL), 4, int'(PPT_SEL), DEPTH) ||
    f_overlap(int'(DPT_SEL), DEPTH, int'(PPT_SEL), DEPTH);

  generate
    if (SEL_OVERLAP) begin : g_sel_overlap
      $error("sregs_mmu: CTRL, DPT and PPT select windows overlap");
    end
  endgenerate

  typedef struct packed {
    logic             valid;
    logic             wp;
    logic [PPN_W-1:0] ppn;
  } pte_t;

  typedef struct packed {
    logic ovf;
    logic cause;  // 0 invalid page, 1 write-protect
    logic chan;   // 0 data, 1 program
    logic valid;
  } fstat_t;

  function automatic pte_t f_pte_wr(logic [15:0] d);
    pte_t p;
    p.valid = d[15];
    p.wp    = d[14];
    p.ppn   = d[PPN_W-1:0];
    return p;
  endfunction

  function automatic logic [15:0] f_pte_rd(pte_t p);
    logic [15:0] v;
    v            = '0;
    v[15]        = p.valid;
    v[14]        = p.wp;
    v[PPN_W-1:0] = p.ppn;
    return v;
  endfunction

  logic         r_den, r_pen, r_pen_buf;
  logic [1:0]   r_saved;
  fstat_t       r_fstat;
  logic [VADDR_W-1:0] r_faddr;
  pte_t         r_dpt [DEPTH];
  pte_t         r_ppt [DEPTH];

  // Select decode: offsets wrap, so a single unsigned compare covers both bounds.
  logic [15:0]           w_ctrl_off, w_dpt_off, w_ppt_off;
  logic                  w_ctrl_hit, w_dpt_hit, w_ppt_hit;
  logic [PAGE_IDX_W-1:0] w_dpt_idx, w_ppt_idx;
  logic                  w_wr, w_ctrl_wr, w_fclr;

  assign w_ctrl_off = i_sr_sel - CTRL_SEL;
  assign w_dpt_off  = i_sr_sel - DPT_SEL;
  assign w_ppt_off  = i_sr_sel - PPT_SEL;
  assign w_ctrl_hit = w_ctrl_off < 16'd4;
  assign w_dpt_hit  = w_dpt_off < 16'(DEPTH);
  assign w_ppt_hit  = w_ppt_off < 16'(DEPTH);
  assign w_dpt_idx  = w_dpt_off[PAGE_IDX_W-1:0];
  assign w_ppt_idx  = w_ppt_off[PAGE_IDX_W-1:0];

  assign w_wr      = i_sr_ie & i_sup;
  assign w_ctrl_wr = w_wr & w_ctrl_hit & (w_ctrl_off[1:0] == 2'd0);
  assign w_fclr    = w_wr & w_ctrl_hit & (w_ctrl_off[1:0] == 2'd3);

  // Translation and fault detection are purely combinational.
  pte_t w_d_pte, w_p_pte;
  logic w_d_fault, w_p_fault;

  assign w_d_pte = r_dpt[i_d_vaddr[VADDR_W-1 -: PAGE_IDX_W]];
  assign w_p_pte = r_ppt[i_p_vaddr[VADDR_W-1 -: PAGE_IDX_W]];

  assign o_d_paddr = r_den ? {w_d_pte.ppn, i_d_vaddr[OFF_W-1:0]} : PADDR_W'(i_d_vaddr);
  assign o_p_paddr = r_pen ? {w_p_pte.ppn, i_p_vaddr[OFF_W-1:0]} : PADDR_W'(i_p_vaddr);
  assign o_p_page  = r_pen ? w_p_pte.ppn : '0;

  assign w_d_fault = r_den & i_d_req & (~w_d_pte.valid | (i_d_we & w_d_pte.wp & ~i_sup));
  assign w_p_fault = r_pen & i_p_req & ~w_p_pte.valid;

  assign o_d_fault    = w_d_fault;
  assign o_p_fault    = w_p_fault;
  assign o_fault_pend = r_fstat.valid;

  // NOTE: every output of this always_comb gets a default first so that no
  // path through the case/if chain leaves it unassigned (which infers a latch).
  always_comb begin
    o_sr_out = '0;
    if (w_ctrl_hit) begin
      case (w_ctrl_off[1:0])
        2'd0:    o_sr_out = {11'b0, r_saved, r_pen_buf, r_pen, r_den};
        2'd1:    o_sr_out = {12'b0, r_fstat};
        2'd2:    o_sr_out = 16'(r_faddr);
        default: o_sr_out = '0;
      endcase
    end else if (w_dpt_hit) begin
      o_sr_out = f_pte_rd(r_dpt[w_dpt_idx]);
    end else if (w_ppt_hit) begin
      o_sr_out = f_pte_rd(r_ppt[w_ppt_idx]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_den     <= 1'b0;
      r_pen     <= 1'b0;
      r_pen_buf <= 1'b0;
      r_saved   <= 2'b00;
      r_fstat   <= '0;
      r_faddr   <= '0;
      // NOTE: the page tables are reset on purpose: an entry left at power-up
      // garbage could translate with valid=1 before software programs it.
      for (int i = 0; i < DEPTH; i++) begin
        r_dpt[i] <= '0;
        r_ppt[i] <= '0;
      end
    end else begin
      // Interrupt entry overrides any same-cycle CTRL write or jump commit.
      if (i_irq_entry) begin
        r_saved   <= {r_pen, r_den};
        r_den     <= 1'b0;
        r_pen     <= 1'b0;
        r_pen_buf <= 1'b0;
      end else begin
        if (w_ctrl_wr) begin
          r_den     <= i_sr_in[0];
          r_pen_buf <= i_sr_in[2];
        end
        if (i_jmp_commit) begin
          r_pen <= r_pen_buf;
        end
      end

      // A fault beats a same-cycle FCLR and is latched fresh; data wins over program.
      if (w_d_fault || w_p_fault) begin
        if (!r_fstat.valid || w_fclr) begin
          r_fstat.valid <= 1'b1;
          r_fstat.chan  <= ~w_d_fault;
          r_fstat.cause <= w_d_fault & w_d_pte.valid;
          r_fstat.ovf   <= 1'b0;
          r_faddr       <= w_d_fault ? i_d_vaddr : i_p_vaddr;
        end else begin
          r_fstat.ovf <= 1'b1;
        end
      end else if (w_fclr) begin
        r_fstat <= '0;
        r_faddr <= '0;
      end

      if (w_wr && w_dpt_hit) begin
        r_dpt[w_dpt_idx] <= f_pte_wr(i_sr_in);
      end
      if (w_wr && w_ppt_hit) begin
        r_ppt[w_ppt_idx] <= f_pte_wr(i_sr_in);
      end
    end
  end

  // Only some write-data bits are stored; the rest are intentionally ignored.
  logic w_unused;
  assign w_unused = ^i_sr_in;

endmodule

// File: tb/tb_sregs_mmu.sv
// Directed testbench for sregs_mmu: a table of combinational translation /
// readback vectors plus hand-written sequences for the fault latch, CTRL
// hand-off (pen_buf/jmp_commit/irq_entry), FCLR races and mid-run reset.
module tb_sregs_mmu;

  localparam logic [15:0] CTRL  = 16'h0040;
  localparam logic [15:0] FSTAT = 16'h0041;
  localparam logic [15:0] FADDR = 16'h0042;
  localparam logic [15:0] FCLR  = 16'h0043;
  localparam logic [15:0] DPT   = 16'h0050;
  localparam logic [15:0] PPT   = 16'h0060;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_sr_ie;
  logic [15:0] i_sr_sel, i_sr_in, o_sr_out;
  logic        i_sup, i_irq_entry, i_jmp_commit;
  logic        i_d_req, i_d_we, i_p_req;
  logic [15:0] i_d_vaddr, i_p_vaddr;
  logic [19:0] o_d_paddr, o_p_paddr;
  logic [7:0]  o_p_page;
  logic        o_d_fault, o_p_fault, o_fault_pend;

  int n_vec = 0;
  int n_err = 0;

  sregs_mmu dut (
    .clk          (clk),
    .rst          (rst),
    .i_sr_ie      (i_sr_ie),
    .i_sr_sel     (i_sr_sel),
    .i_sr_in      (i_sr_in),
    .o_sr_out     (o_sr_out),
    .i_sup        (i_sup),
    .i_irq_entry  (i_irq_entry),
    .i_jmp_commit (i_jmp_commit),
    .i_d_req      (i_d_req),
    .i_d_we       (i_d_we),
    .i_d_vaddr    (i_d_vaddr),
    .o_d_paddr    (o_d_paddr),
    .i_p_req      (i_p_req),
    .i_p_vaddr    (i_p_vaddr),
    .o_p_paddr    (o_p_paddr),
    .o_p_page     (o_p_page),
    .o_d_fault    (o_d_fault),
    .o_p_fault    (o_p_fault),
    .o_fault_pend (o_fault_pend)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (n_err=%0d)", n_err);
    $fatal(1);
  end

  typedef struct {
    logic [15:0] sel;
    logic        d_req, d_we, sup;
    logic [15:0] d_va;
    logic        p_req;
    logic [15:0] p_va;
    logic [19:0] e_dpa;
    logic        e_df;
    logic [19:0] e_ppa;
    logic        e_pf;
    logic [15:0] e_sr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; results are read 1 ns later.
  task automatic rd(input logic [15:0] sel, input logic [15:0] exp, input string name);
    @(negedge clk);
    i_sr_sel = sel;
    #1;
    check(name, {16'h0, o_sr_out}, {16'h0, exp});
  endtask

  task automatic sr_write(input logic [15:0] sel, input logic [15:0] data, input logic sup);
    @(negedge clk);
    i_sr_sel = sel;
    i_sr_in  = data;
    i_sup    = sup;
    i_sr_ie  = 1'b1;
    @(negedge clk);
    i_sr_ie  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_sr_ie = 0; i_sr_sel = 0; i_sr_in = 0; i_sup = 0;
    i_irq_entry = 0; i_jmp_commit = 0; i_d_req = 0; i_d_we = 0; i_p_req = 0;
    i_d_vaddr = 0; i_p_vaddr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // --- after reset: identity translation, empty tables, no fault ---
    @(negedge clk);
    i_d_req = 1; i_d_vaddr = 16'hFAAA; i_p_req = 1; i_p_vaddr = 16'h1234;
    #1;
    check("rst_d_paddr", {12'h0, o_d_paddr}, 32'h0FAAA);
    check("rst_p_paddr", {12'h0, o_p_paddr}, 32'h01234);
    check("rst_p_page", {24'h0, o_p_page}, 32'h0);
    check("rst_faults", {30'h0, o_d_fault, o_p_fault}, 32'h0);
    check("rst_fault_pend", {31'h0, o_fault_pend}, 32'h0);
    i_d_req = 0; i_p_req = 0;
    rd(DPT + 16'd15, 16'h0000, "rst_dpt15");
    rd(FSTAT, 16'h0000, "rst_fstat");

    // --- program tables and enable data paging ---
    sr_write(DPT + 16'd15, 16'h8012, 1'b1);
    sr_write(DPT + 16'd3,  16'hFF34, 1'b1);   // unused bits must read back 0
    sr_write(PPT + 16'd2,  16'h8077, 1'b1);
    sr_write(CTRL, 16'h0001, 1'b1);

    // --- table-driven combinational vectors (den=1, pen=0) ---
    vecs[0] = '{16'h005F, 1, 0, 1, 16'hFAAA, 1, 16'h2ABC, 20'h12AAA, 0, 20'h02ABC, 0, 16'h8012};
    vecs[1] = '{16'h0053, 1, 1, 1, 16'h3001, 1, 16'h5000, 20'h34001, 0, 20'h05000, 0, 16'hC034};
    vecs[2] = '{16'h0040, 1, 0, 0, 16'h3001, 0, 16'h0000, 20'h34001, 0, 20'h00000, 0, 16'h0001};
    vecs[3] = '{16'h0062, 1, 1, 0, 16'h3001, 0, 16'h0000, 20'h34001, 1, 20'h00000, 0, 16'h8077};
    vecs[4] = '{16'h0100, 1, 0, 1, 16'h7123, 0, 16'h0000, 20'h00123, 1, 20'h00000, 0, 16'h0000};
    vecs[5] = '{16'h0041, 0, 0, 1, 16'h7123, 1, 16'hFFFF, 20'h00123, 0, 20'h0FFFF, 0, 16'h0000};
    vecs[6] = '{16'h0065, 1, 1, 0, 16'h3FFF, 0, 16'h0000, 20'h34FFF, 1, 20'h00000, 0, 16'h0000};
    vecs[7] = '{16'h0050, 1, 0, 1, 16'h0000, 0, 16'h0000, 20'h00000, 1, 20'h00000, 0, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      i_sr_sel = vecs[i].sel; i_d_req = vecs[i].d_req; i_d_we = vecs[i].d_we;
      i_sup = vecs[i].sup; i_d_vaddr = vecs[i].d_va;
      i_p_req = vecs[i].p_req; i_p_vaddr = vecs[i].p_va;
      #1;
      check($sformatf("vec%0d_d_paddr", i), {12'h0, o_d_paddr}, {12'h0, vecs[i].e_dpa});
      check($sformatf("vec%0d_d_fault", i), {31'h0, o_d_fault}, {31'h0, vecs[i].e_df});
      check($sformatf("vec%0d_p_paddr", i), {12'h0, o_p_paddr}, {12'h0, vecs[i].e_ppa});
      check($sformatf("vec%0d_p_fault", i), {31'h0, o_p_fault}, {31'h0, vecs[i].e_pf});
      check($sformatf("vec%0d_sr_out", i), {16'h0, o_sr_out}, {16'h0, vecs[i].e_sr});
      #1;
      i_d_req = 0; i_p_req = 0; i_d_we = 0;   // no request is live at the edge
    end
    rd(FSTAT, 16'h0000, "table_no_latch");

    // --- user-mode writes are dropped ---
    sr_write(DPT + 16'd15, 16'h0000, 1'b0);
    sr_write(CTRL, 16'h0000, 1'b0);
    rd(DPT + 16'd15, 16'h8012, "user_wr_pte");
    rd(CTRL, 16'h0001, "user_wr_ctrl");
    @(negedge clk);
    i_d_vaddr = 16'hFAAA; #1;
    check("user_wr_xlate", {12'h0, o_d_paddr}, 32'h12AAA);

    // --- PTE write visible to translation only from the next cycle ---
    @(negedge clk);
    i_d_vaddr = 16'h1234; i_sr_sel = DPT + 16'd1; i_sr_in = 16'h8099;
    i_sup = 1; i_sr_ie = 1; #1;
    check("pte_same_cycle", {12'h0, o_d_paddr}, 32'h00234);
    @(negedge clk);
    i_sr_ie = 0; #1;
    check("pte_next_cycle", {12'h0, o_d_paddr}, 32'h99234);

    // --- write-protect fault latch, then overflow ---
    @(negedge clk);
    i_sup = 0; i_d_we = 1; i_d_req = 1; i_d_vaddr = 16'h3001; #1;
    check("wp_d_fault", {31'h0, o_d_fault}, 32'h1);
    @(negedge clk);
    i_d_req = 0; i_d_we = 0; #1;
    check("wp_fault_pend", {31'h0, o_fault_pend}, 32'h1);
    rd(FSTAT, 16'h0005, "wp_fstat");
    rd(FADDR, 16'h3001, "wp_faddr");
    @(negedge clk);
    i_d_req = 1; i_d_vaddr = 16'h7123;
    @(negedge clk);
    i_d_req = 0;
    rd(FSTAT, 16'h000D, "ovf_fstat");
    rd(FADDR, 16'h3001, "ovf_faddr_kept");

    // --- pen_buf / jmp_commit / irq_entry ---
    sr_write(CTRL, 16'h0004, 1'b1);
    rd(CTRL, 16'h0004, "pen_buf_only");
    @(negedge clk);
    i_irq_entry = 1; i_jmp_commit = 1;
    @(negedge clk);
    i_irq_entry = 0; i_jmp_commit = 0;
    rd(CTRL, 16'h0000, "irq_beats_jmp");
    sr_write(CTRL, 16'h0005, 1'b1);
    @(negedge clk);
    i_p_vaddr = 16'h2ABC; i_p_req = 1; #1;
    check("pen_off_p_paddr", {12'h0, o_p_paddr}, 32'h02ABC);
    i_p_req = 0;
    @(negedge clk);
    i_jmp_commit = 1;
    @(negedge clk);
    i_jmp_commit = 0; #1;
    check("pen_on_p_paddr", {12'h0, o_p_paddr}, 32'h77ABC);
    check("pen_on_p_page", {24'h0, o_p_page}, 32'h77);
    rd(CTRL, 16'h0007, "jmp_ctrl");
    @(negedge clk);
    i_irq_entry = 1;
    @(negedge clk);
    i_irq_entry = 0; #1;
    check("irq_p_paddr", {12'h0, o_p_paddr}, 32'h02ABC);
    rd(CTRL, 16'h0018, "irq_saved");
    rd(FSTAT, 16'h000D, "irq_keeps_fstat");
    @(negedge clk);
    i_sr_sel = CTRL; i_sr_in = 16'h0005; i_sup = 1; i_sr_ie = 1; i_irq_entry = 1;
    @(negedge clk);
    i_sr_ie = 0; i_irq_entry = 0;
    rd(CTRL, 16'h0000, "irq_beats_write");
    sr_write(CTRL, 16'h0005, 1'b1);
    @(negedge clk);
    i_jmp_commit = 1;
    @(negedge clk);
    i_jmp_commit = 0;
    rd(CTRL, 16'h0007, "pen_den_on");

    // --- FCLR, dual fault, FCLR racing a fault ---
    sr_write(FCLR, 16'h0000, 1'b1);
    rd(FSTAT, 16'h0000, "fclr_fstat");
    rd(FADDR, 16'h0000, "fclr_faddr");
    @(negedge clk);
    i_d_req = 1; i_d_vaddr = 16'h7123; i_p_req = 1; i_p_vaddr = 16'h5000; #1;
    check("dual_faults", {30'h0, o_d_fault, o_p_fault}, 32'h3);
    @(negedge clk);
    i_d_req = 0; i_p_req = 0;
    rd(FSTAT, 16'h0001, "dual_fstat");
    rd(FADDR, 16'h7123, "dual_faddr");
    @(negedge clk);
    i_sr_sel = FCLR; i_sr_in = 16'h0000; i_sup = 1; i_sr_ie = 1;
    i_p_req = 1; i_p_vaddr = 16'h5432;
    @(negedge clk);
    i_sr_ie = 0; i_p_req = 0;
    rd(FSTAT, 16'h0003, "fclr_race_fstat");
    rd(FADDR, 16'h5432, "fclr_race_faddr");
    sr_write(FCLR, 16'h0000, 1'b0);
    rd(FSTAT, 16'h0003, "user_fclr_dropped");
    sr_write(FCLR, 16'h0000, 1'b1);

    // --- reset in the middle of a translated access ---
    @(negedge clk);
    i_d_req = 1; i_d_vaddr = 16'hFAAA; #1;
    check("pre_rst_xlate", {12'h0, o_d_paddr}, 32'h12AAA);
    rst = 1;
    @(negedge clk);
    rst = 0; #1;
    check("post_rst_xlate", {12'h0, o_d_paddr}, 32'h0FAAA);
    check("post_rst_fault", {31'h0, o_d_fault}, 32'h0);
    i_d_req = 0;
    for (int i = 0; i < 16; i++) begin
      rd(DPT + 16'(i), 16'h0000, $sformatf("post_rst_dpt%0d", i));
      rd(PPT + 16'(i), 16'h0000, $sformatf("post_rst_ppt%0d", i));
    end
    rd(CTRL, 16'h0000, "post_rst_ctrl");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
